// File: rtl/sd_clock_gen_if.sv
// Control and status bundle between the SD controller and its clock generator.
// The controller side is the master; the generator side is the slave.
interface sd_clock_gen_if #(
   parameter int DIV_W = 8
);
   logic [DIV_W-1:0] DIVIDER;      // requested half-period minus one
   logic             DIV_LOAD;     // one-cycle request to adopt DIVIDER
   logic             DIV_ACK;      // one-cycle pulse when the new ratio takes effect
   logic             CLK_EN;       // level: run the SD clock
   logic             CLK_STOPPED;  // SD clock parked low, generator idle
   logic             SD_CLK;       // divided clock
   logic             SD_RISE;      // SD_CLK has just risen
   logic             SD_FALL;      // SD_CLK has just fallen

   modport master (
      output DIVIDER, DIV_LOAD, CLK_EN,
      input  DIV_ACK, CLK_STOPPED, SD_CLK, SD_RISE, SD_FALL
   );

   modport slave (
      input  DIVIDER, DIV_LOAD, CLK_EN,
      output DIV_ACK, CLK_STOPPED, SD_CLK, SD_RISE, SD_FALL
   );
endinterface

// File: rtl/sd_clock_gen.sv
// SD card clock generator: divides CLK by 2*(D+1) with a registered 50 % duty
// SD_CLK. Ratio changes land only on a falling edge (or while idle) and stops
// land only at the end of a full low phase, so no runt pulse is ever produced.
// SD_RISE/SD_FALL are CLK-domain strobes for the command and data paths.
module sd_clock_gen #(
   parameter int          DIV_W   = 8,
   parameter int unsigned RST_DIV = 124
) (
   input  logic            CLK,
   input  logic            RST,
   sd_clock_gen_if.slave   bus
);

   localparam logic [DIV_W-1:0] RST_DIV_V = DIV_W'(RST_DIV);

   typedef enum logic {IDLE, RUN} state_e;

   state_e           state,   state_nxt;
   logic [DIV_W-1:0] cnt,     cnt_nxt;
   logic [DIV_W-1:0] div_q,   div_q_nxt;
   logic [DIV_W-1:0] div_p,   div_p_nxt;
   logic             pend,    pend_nxt;
   logic             first,   first_nxt;    // first cycle of RUN after a start
   logic             sd_clk,  sd_clk_nxt;
   logic             rise,    rise_nxt;
   logic             fall,    fall_nxt;
   logic             ack,     ack_nxt;
   logic             stopped, stopped_nxt;

   logic [DIV_W-1:0] div_eff;
   logic             apply;

   // A load captured on the same edge that started the clock must already
   // govern the first low phase, so that phase compares against div_p.
   assign div_eff = (first && pend) ? div_p : div_q;

   // Next-state and output decode for the IDLE/RUN machine.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path can infer a latch.
      state_nxt   = state;
      cnt_nxt     = cnt;
      div_q_nxt   = div_q;
      div_p_nxt   = div_p;
      pend_nxt    = pend;
      first_nxt   = 1'b0;
      sd_clk_nxt  = sd_clk;
      rise_nxt    = 1'b0;
      fall_nxt    = 1'b0;
      ack_nxt     = 1'b0;
      stopped_nxt = stopped;
      apply       = 1'b0;

      unique case (state)
         IDLE: begin
            sd_clk_nxt = 1'b0;
            cnt_nxt    = '0;
            if (pend) begin
               apply = 1'b1;
            end
            if (bus.CLK_EN) begin
               state_nxt   = RUN;
               stopped_nxt = 1'b0;
               first_nxt   = 1'b1;
            end
         end

         RUN: begin
            if (first && pend) begin
               apply = 1'b1;
            end
            if (cnt != div_eff) begin
               cnt_nxt = cnt + 1'b1;
            end else begin
               cnt_nxt = '0;
               if (sd_clk) begin
                  // End of a high phase: always completes, CLK_EN is ignored.
                  sd_clk_nxt = 1'b0;
                  fall_nxt   = 1'b1;
                  if (pend) begin
                     apply = 1'b1;
                  end
               end else if (bus.CLK_EN) begin
                  sd_clk_nxt = 1'b1;
                  rise_nxt   = 1'b1;
               end else begin
                  // Full low phase done and clock disabled: park low.
                  state_nxt   = IDLE;
                  stopped_nxt = 1'b1;
               end
            end
         end

         default: state_nxt = IDLE;
      endcase

      if (apply) begin
         div_q_nxt = div_p;
         pend_nxt  = 1'b0;
         ack_nxt   = 1'b1;
      end

      // A fresh request wins over a simultaneous apply: it stays pending.
      if (bus.DIV_LOAD) begin
         div_p_nxt = bus.DIVIDER;
         pend_nxt  = 1'b1;
      end
   end

   // State and output registers; every output comes straight from a flop.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= IDLE;
         cnt     <= '0;
         div_q   <= RST_DIV_V;
         // NOTE: div_p is only read while pend is set, but resetting it keeps it X-free.
         div_p   <= '0;
         pend    <= 1'b0;
         first   <= 1'b0;
         sd_clk  <= 1'b0;
         rise    <= 1'b0;
         fall    <= 1'b0;
         ack     <= 1'b0;
         stopped <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         div_q   <= div_q_nxt;
         div_p   <= div_p_nxt;
         pend    <= pend_nxt;
         first   <= first_nxt;
         sd_clk  <= sd_clk_nxt;
         rise    <= rise_nxt;
         fall    <= fall_nxt;
         ack     <= ack_nxt;
         stopped <= stopped_nxt;
      end
   end

   assign bus.SD_CLK      = sd_clk;
   assign bus.SD_RISE     = rise;
   assign bus.SD_FALL     = fall;
   assign bus.DIV_ACK     = ack;
   assign bus.CLK_STOPPED = stopped;

endmodule

// File: tb/tb_sd_clock_gen.sv
// Bench for sd_clock_gen: expected SD_RISE/SD_FALL/DIV_ACK events (kind and
// CLK edge number) are queued as stimulus is driven and matched against the
// strobes the generator produces; level checks cover reset and stop/restart.
module tb_sd_clock_gen;

   localparam int EV_RISE = 1;
   localparam int EV_FALL = 2;
   localparam int EV_ACK  = 3;

   typedef struct {
      int kind;
      int cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   ev_t  sb[$];

   sd_clock_gen_if #(.DIV_W(8)) bus ();

   sd_clock_gen #(.DIV_W(8), .RST_DIV(124)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Edge counter: value seen at a negedge is the number of the preceding posedge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int obs, input int exp_v);
      n_checks++;
      if (obs == exp_v) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
   endtask

   task automatic expect_ev(input int kind, input int at);
      ev_t e;
      e.kind = kind;
      e.cyc  = at;
      sb.push_back(e);
   endtask

   task automatic observe(input int kind);
      ev_t e;
      if (sb.size() == 0) begin
         check("spurious_event", kind, 0);
      end else begin
         e = sb.pop_front();
         check("event_kind", kind, e.kind);
         check("event_cycle", cyc, e.cyc);
      end
   endtask

   // Strobe monitor, sampled half a clock after the edge that produced it.
   always @(negedge clk) begin
      if (bus.SD_RISE) begin
         observe(EV_RISE);
         check("rise_level", int'(bus.SD_CLK), 1);
      end
      if (bus.SD_FALL) begin
         observe(EV_FALL);
         check("fall_level", int'(bus.SD_CLK), 0);
      end
      if (bus.DIV_ACK) observe(EV_ACK);
   end

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Pulse DIV_LOAD while idle: ack two edges after the pulse is driven.
   task automatic load_idle(input int v);
      int n;
      @(negedge clk);
      bus.DIVIDER  = 8'(v);
      bus.DIV_LOAD = 1'b1;
      n = cyc;
      expect_ev(EV_ACK, n + 2);
      @(negedge clk);
      bus.DIV_LOAD = 1'b0;
      wait_until(n + 3);
      check("idle_load_done", sb.size(), 0);
   endtask

   // Start with divider d, run the given number of periods, stop during the
   // last high phase, and confirm the clock parks low after a full low phase.
   task automatic run_periods(input int d, input int periods);
      int k, r, s;
      @(negedge clk);
      bus.CLK_EN = 1'b1;
      k = cyc + 1;
      for (int p = 0; p < periods; p++) begin
         expect_ev(EV_RISE, k + (2 * p + 1) * (d + 1));
         expect_ev(EV_FALL, k + (2 * p + 2) * (d + 1));
      end
      wait_until(k);
      check("stopped_after_start", int'(bus.CLK_STOPPED), 0);
      r = k + (2 * periods - 1) * (d + 1);
      wait_until(r);
      check("high_at_last_rise", int'(bus.SD_CLK), 1);
      bus.CLK_EN = 1'b0;
      s = r + 2 * (d + 1);
      wait_until(s - 1);
      check("running_before_stop", int'(bus.CLK_STOPPED), 0);
      wait_until(s);
      check("stopped_flag", int'(bus.CLK_STOPPED), 1);
      check("parked_low", int'(bus.SD_CLK), 0);
      repeat (2 * (d + 1) + 3) @(negedge clk);
      check("still_parked", int'(bus.SD_CLK), 0);
      check("all_events_seen", sb.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: run exceeded its time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      bus.DIVIDER  = '0;
      bus.DIV_LOAD = 1'b0;
      bus.CLK_EN   = 1'b0;

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_sd_clk", int'(bus.SD_CLK), 0);
      check("rst_stopped", int'(bus.CLK_STOPPED), 1);
      check("rst_ack", int'(bus.DIV_ACK), 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_sd_clk", int'(bus.SD_CLK), 0);
      check("idle_stopped", int'(bus.CLK_STOPPED), 1);

      // Ratio sweep.
      load_idle(0);
      run_periods(0, 4);
      load_idle(255);
      run_periods(255, 2);

      // Stop/restart with D=3: restart rises exactly 4 cycles after enable.
      load_idle(3);
      run_periods(3, 3);
      run_periods(3, 2);

      // Divider change in RUN: load 1 mid-high phase of D=3.
      @(negedge clk);
      bus.CLK_EN = 1'b1;
      k = cyc + 1;
      expect_ev(EV_RISE, k + 4);
      expect_ev(EV_FALL, k + 8);
      expect_ev(EV_RISE, k + 12);
      expect_ev(EV_FALL, k + 16);
      expect_ev(EV_ACK,  k + 16);
      expect_ev(EV_RISE, k + 18);
      expect_ev(EV_FALL, k + 20);
      expect_ev(EV_RISE, k + 22);
      expect_ev(EV_FALL, k + 24);
      wait_until(k + 13);
      bus.DIVIDER  = 8'd1;
      bus.DIV_LOAD = 1'b1;
      @(negedge clk);
      bus.DIV_LOAD = 1'b0;
      wait_until(k + 15);
      check("high_kept_during_load", int'(bus.SD_CLK), 1);
      wait_until(k + 22);
      bus.CLK_EN = 1'b0;
      wait_until(k + 26);
      check("chg_stopped", int'(bus.CLK_STOPPED), 1);
      repeat (5) @(negedge clk);
      check("chg_events_seen", sb.size(), 0);

      // Back-to-back loads (5 then 2) in one low phase of D=3.
      load_idle(3);
      @(negedge clk);
      bus.CLK_EN = 1'b1;
      k = cyc + 1;
      expect_ev(EV_RISE, k + 4);
      expect_ev(EV_FALL, k + 8);
      expect_ev(EV_RISE, k + 12);
      expect_ev(EV_FALL, k + 16);
      expect_ev(EV_ACK,  k + 16);
      expect_ev(EV_RISE, k + 19);
      expect_ev(EV_FALL, k + 22);
      expect_ev(EV_RISE, k + 25);
      expect_ev(EV_FALL, k + 28);
      wait_until(k + 8);
      bus.DIVIDER  = 8'd5;
      bus.DIV_LOAD = 1'b1;
      wait_until(k + 9);
      bus.DIV_LOAD = 1'b0;
      wait_until(k + 10);
      bus.DIVIDER  = 8'd2;
      bus.DIV_LOAD = 1'b1;
      wait_until(k + 11);
      bus.DIV_LOAD = 1'b0;
      wait_until(k + 25);
      bus.CLK_EN = 1'b0;
      wait_until(k + 31);
      check("b2b_stopped", int'(bus.CLK_STOPPED), 1);
      repeat (5) @(negedge clk);
      check("b2b_events_seen", sb.size(), 0);

      // Load 7 and start together from D=0: new ratio governs first half-period.
      load_idle(0);
      @(negedge clk);
      bus.DIVIDER  = 8'd7;
      bus.DIV_LOAD = 1'b1;
      bus.CLK_EN   = 1'b1;
      k = cyc + 1;
      expect_ev(EV_ACK,  k + 1);
      expect_ev(EV_RISE, k + 8);
      expect_ev(EV_FALL, k + 16);
      @(negedge clk);
      bus.DIV_LOAD = 1'b0;
      wait_until(k + 8);
      bus.CLK_EN = 1'b0;
      wait_until(k + 23);
      check("joint_running", int'(bus.CLK_STOPPED), 0);
      wait_until(k + 24);
      check("joint_stopped", int'(bus.CLK_STOPPED), 1);
      repeat (3) @(negedge clk);
      check("joint_events_seen", sb.size(), 0);

      // Reset mid-high phase with a load pending: no fall, no ack.
      load_idle(3);
      @(negedge clk);
      bus.CLK_EN = 1'b1;
      k = cyc + 1;
      expect_ev(EV_RISE, k + 4);
      wait_until(k + 4);
      bus.DIVIDER  = 8'd9;
      bus.DIV_LOAD = 1'b1;
      wait_until(k + 5);
      bus.DIV_LOAD = 1'b0;
      bus.CLK_EN   = 1'b0;
      check("pre_reset_high", int'(bus.SD_CLK), 1);
      rst = 1'b0;
      #1;
      check("async_rst_sd_clk", int'(bus.SD_CLK), 0);
      check("async_rst_stopped", int'(bus.CLK_STOPPED), 1);
      check("async_rst_ack", int'(bus.DIV_ACK), 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      check("post_reset_events", sb.size(), 0);
      check("post_reset_stopped", int'(bus.CLK_STOPPED), 1);
      // Reset divider restored: first rise 125 cycles after enable.
      run_periods(124, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sd_clock_gen.md
# sd_clock_gen

Parametrised SD card clock generator for the SD controller: divides the system clock `CLK` by a runtime-programmable even ratio and produces a registered 50 % duty `SD_CLK`. Divider changes and clock stop/start are glitch-free, with no runt pulses. The block also emits one-cycle `SD_RISE`/`SD_FALL` strobes in the `CLK` domain, which the command and data paths use for launch and capture. It replaces the fixed 8-bit divider in the controller's clock path.

## Interface
Parameters:
- `DIV_W`, 8: width of the divider value.
- `RST_DIV`, 124: divider value loaded at reset; gives 400 kHz from 100 MHz.

Ports:
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `DIVIDER`  in  `DIV_W`  new divider value D; half-period = D+1 `CLK` cycles.
- `DIV_LOAD`  in  1  one-cycle request to adopt `DIVIDER`.
- `DIV_ACK`  out  1  one-cycle pulse when the pending divider is applied.
- `CLK_EN`  in  1  level; 1 = run `SD_CLK`, 0 = stop it low.
- `CLK_STOPPED`  out  1  1 while `SD_CLK` is parked low and the generator is idle.
- `SD_CLK`  out  1  divided clock, driven directly from a flop.
- `SD_RISE`  out  1  high for the `CLK` cycle in which `SD_CLK` has just risen.
- `SD_FALL`  out  1  high for the `CLK` cycle in which `SD_CLK` has just fallen.

## Operation
- Internal state:
  - `div_q` (`DIV_W`): active divider.
  - `div_p` (`DIV_W`): pending divider.
  - `pend` (1): load request outstanding.
  - `cnt` (`DIV_W`): phase counter.
  - FSM with states IDLE and RUN.
- Reset values (while `RST`=0): `SD_CLK`=0, `SD_RISE`=0, `SD_FALL`=0, `DIV_ACK`=0, `CLK_STOPPED`=1, `cnt`=0, `div_q`=`RST_DIV`, `pend`=0, state IDLE.
- `DIV_LOAD`=1: `div_p`<=`DIVIDER`, `pend`<=1.
  - A later `DIV_LOAD` before application overwrites `div_p`. Only the last value is applied, with a single `DIV_ACK`.
- IDLE:
  - `SD_CLK` held 0, `cnt` held 0.
  - If `pend`: `div_q`<=`div_p`, `pend`<=0, `DIV_ACK`=1 on the next cycle.
  - If `CLK_EN`=1: go to RUN, `cnt`<=0, `CLK_STOPPED`<=0.
  - `DIV_LOAD` and `CLK_EN` rising together: the new divider governs the first half-period.
- RUN, with `cnt`≠`div_q`: `cnt`<=`cnt`+1.
- RUN, with `cnt`==`div_q` (terminal count):
  - `SD_CLK`=0 and `CLK_EN`=1: `SD_CLK`<=1, `SD_RISE`<=1, `cnt`<=0.
  - `SD_CLK`=0 and `CLK_EN`=0: no toggle. Go to IDLE, `CLK_STOPPED`<=1, `cnt`<=0. The stop only ever happens after a full low phase.
  - `SD_CLK`=1: `SD_CLK`<=0, `SD_FALL`<=1, `cnt`<=0. If `pend`: `div_q`<=`div_p`, `pend`<=0, `DIV_ACK`<=1 in the same edge. The new ratio governs the low phase that starts at this edge. `CLK_EN` is ignored in the high phase, so a high phase is never truncated.
- Output strobes: `SD_RISE`, `SD_FALL` and `DIV_ACK` are registered single-cycle pulses, 0 otherwise.
- Counter width: `cnt` never exceeds `div_q`, so it never wraps. D = 2^`DIV_W`−1 gives half-period 2^`DIV_W` cycles.
- D=0: `SD_CLK` = `CLK`/2. Strobes alternate every cycle.

## Timing
- Period = 2·(D+1) `CLK` cycles. Duty cycle is exactly 50 % for every D.
- Start: `CLK_EN` sampled 1 in IDLE at posedge k.
  - `CLK_STOPPED` falls after k.
  - First `SD_CLK` rise at posedge k+D+1; first fall at k+2(D+1).
- Stop: `CLK_EN` low takes effect at the first terminal count of a low phase. The worst-case latency from deassertion to `CLK_STOPPED`=1 is 2(D+1) cycles.
- Divider latency:
  - In IDLE, `DIV_ACK` fires 2 cycles after the `DIV_LOAD` pulse (capture, then apply).
  - In RUN, it fires at the next `SD_CLK` falling edge that occurs at least 1 cycle after capture.
- `SD_RISE`/`SD_FALL` are asserted in the same cycle `SD_CLK` shows the new level.
- Reset mid-operation: all outputs return to reset values asynchronously, including mid-high phase. A pending load is discarded with no `DIV_ACK`. Release is synchronous to the `CLK` edge; the block comes up IDLE.

## Test plan
- Reset: assert `RST`=0 mid-high phase with D=3 -> `SD_CLK`=0 immediately, `CLK_STOPPED`=1, no `DIV_ACK`; after release, `div_q`=124.
- Ratio sweep: load D=0, D=3 and D=255 with `DIV_W`=8, then `CLK_EN`=1 -> periods 2, 8 and 512 cycles, 50 % duty, exactly one `SD_RISE` and one `SD_FALL` per period, first rise D+1 cycles after start.
- Divider change in RUN: D=3 running; pulse `DIV_LOAD` with 1 mid-high phase -> high phase stays 4 cycles; `DIV_ACK` coincides with the fall; following phases are 2 cycles; no runt pulse.
- Back-to-back loads: `DIV_LOAD` with 5 then with 2 within one phase -> a single `DIV_ACK`, and the ratio becomes 2.
- Stop/restart: drop `CLK_EN` during a high phase with D=3 -> high phase completes, low phase lasts 4 cycles, then `CLK_STOPPED`=1 and `SD_CLK` stays 0. Reassert `CLK_EN` -> rise exactly 4 cycles later.
- IDLE load plus start together: `DIV_LOAD` with 7 and `CLK_EN`=1 in the same cycle -> `DIV_ACK` fires 2 cycles later; first half-period is 8 cycles.
